// File: rtl/adc_frame_aligner.sv
// ---------------------------------------------------------------------------
// adc_frame_aligner
//
// Word-alignment trainer for one ADC channel's two 6-bit deserializer lanes.
// It drives the channel input block's SERDES reset and bitslip controls. It
// keeps doing so until both lanes of the registered adc_bits word match a
// known test pattern for a whole check window. It gives up with fail when a
// lane has used up its bitslip budget.
//
// Training sequence after start:
//   IORST  -> SETTLE -> CHECK -> (SLIP -> SETTLE -> CHECK)* -> LOCKED | FAIL
//
// Ports:
//   lclk          in   frame clock, all logic on posedge
//   rst_n         in   asynchronous active-low reset
//   start         in   1-cycle pulse, begins (re)training when not busy
//   pattern       in   expected word, lane0 = [5:0], lane1 = [11:6]
//   adc_bits      in   aligned-candidate word from the channel input block
//   adc_io_reset  out  per-lane SERDES reset
//   adc_bitslip   out  per-lane bitslip request, 1-cycle pulses
//   busy          out  training in progress
//   locked        out  both lanes matched in one full window
//   fail          out  a lane exhausted P_MAX_SLIPS
//   slip_count_0  out  bitslips issued to lane 0 this training run
//   slip_count_1  out  bitslips issued to lane 1 this training run
// ---------------------------------------------------------------------------
module adc_frame_aligner #(
    parameter int P_IORST_CYCLES  = 4,
    parameter int P_SETTLE_CYCLES = 8,
    parameter int P_MATCH_COUNT   = 16,
    parameter int P_MAX_SLIPS     = 12
) (
    input  logic        lclk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [11:0] pattern,
    input  logic [11:0] adc_bits,
    output logic [1:0]  adc_io_reset,
    output logic [1:0]  adc_bitslip,
    output logic        busy,
    output logic        locked,
    output logic        fail,
    output logic [3:0]  slip_count_0,
    output logic [3:0]  slip_count_1
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_IORST,
        S_SETTLE,
        S_CHECK,
        S_SLIP,
        S_LOCKED,
        S_FAIL
    } state_t;

    // Timed states load "cycles - 1" and leave when the counter reaches zero.
    localparam logic [7:0] IORST_LAST  = 8'(P_IORST_CYCLES - 1);
    localparam logic [7:0] SETTLE_LAST = 8'(P_SETTLE_CYCLES - 1);
    localparam logic [7:0] MATCH_LAST  = 8'(P_MATCH_COUNT - 1);
    localparam logic [3:0] MAX_SLIPS   = 4'(P_MAX_SLIPS);

    state_t      state_q, state_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [1:0]  bad_q, bad_d;
    logic [1:0]  io_reset_q, io_reset_d;
    logic [1:0]  bitslip_q, bitslip_d;
    logic        busy_q, busy_d;
    logic        locked_q, locked_d;
    logic        fail_q, fail_d;
    logic [3:0]  slip0_q, slip0_d;
    logic [3:0]  slip1_q, slip1_d;

    logic [1:0]  mismatch;
    logic [1:0]  bad_now;

    function automatic logic [3:0] sat_inc(input logic [3:0] v);
        return (v == 4'hF) ? v : v + 4'd1;
    endfunction

    // Per-lane compare of this cycle's word. It is merged with the mismatches
    // already seen, so the decision on the last window cycle includes that cycle.
    always_comb begin
        mismatch[0] = (adc_bits[5:0]  != pattern[5:0]);
        mismatch[1] = (adc_bits[11:6] != pattern[11:6]);
        bad_now     = bad_q | mismatch;
    end

    // Next-state logic. Every output register is loaded with the value that
    // belongs to the state being entered, so the outputs line up with the state.
    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        bad_d      = bad_q;
        busy_d     = busy_q;
        locked_d   = locked_q;
        fail_d     = fail_q;
        slip0_d    = slip0_q;
        slip1_d    = slip1_q;
        io_reset_d = 2'b00;
        bitslip_d  = 2'b00;

        case (state_q)
            S_IDLE, S_LOCKED, S_FAIL: begin
                if (start) begin
                    state_d    = S_IORST;
                    cnt_d      = IORST_LAST;
                    busy_d     = 1'b1;
                    locked_d   = 1'b0;
                    fail_d     = 1'b0;
                    slip0_d    = 4'd0;
                    slip1_d    = 4'd0;
                    io_reset_d = 2'b11;
                end
            end

            S_IORST: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_SETTLE;
                    cnt_d   = SETTLE_LAST;
                end else begin
                    cnt_d      = cnt_q - 8'd1;
                    io_reset_d = 2'b11;
                end
            end

            S_SETTLE: begin
                if (cnt_q == 8'd0) begin
                    state_d = S_CHECK;
                    cnt_d   = MATCH_LAST;
                    bad_d   = 2'b00;
                end else begin
                    cnt_d = cnt_q - 8'd1;
                end
            end

            S_CHECK: begin
                bad_d = bad_now;
                if (cnt_q != 8'd0) begin
                    cnt_d = cnt_q - 8'd1;
                end else if (bad_now == 2'b00) begin
                    state_d  = S_LOCKED;
                    locked_d = 1'b1;
                    busy_d   = 1'b0;
                end else if ((bad_now[0] && slip0_q == MAX_SLIPS) ||
                             (bad_now[1] && slip1_q == MAX_SLIPS)) begin
                    state_d  = S_FAIL;
                    fail_d   = 1'b1;
                    locked_d = 1'b0;
                    busy_d   = 1'b0;
                end else begin
                    state_d   = S_SLIP;
                    bitslip_d = bad_now;
                    if (bad_now[0]) begin
                        slip0_d = sat_inc(slip0_q);
                    end
                    if (bad_now[1]) begin
                        slip1_d = sat_inc(slip1_q);
                    end
                end
            end

            S_SLIP: begin
                state_d = S_SETTLE;
                cnt_d   = SETTLE_LAST;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge lclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= S_IDLE;
            cnt_q      <= 8'd0;
            bad_q      <= 2'b00;
            io_reset_q <= 2'b00;
            bitslip_q  <= 2'b00;
            busy_q     <= 1'b0;
            locked_q   <= 1'b0;
            fail_q     <= 1'b0;
            slip0_q    <= 4'd0;
            slip1_q    <= 4'd0;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            bad_q      <= bad_d;
            io_reset_q <= io_reset_d;
            bitslip_q  <= bitslip_d;
            busy_q     <= busy_d;
            locked_q   <= locked_d;
            fail_q     <= fail_d;
            slip0_q    <= slip0_d;
            slip1_q    <= slip1_d;
        end
    end

    assign adc_io_reset = io_reset_q;
    assign adc_bitslip  = bitslip_q;
    assign busy         = busy_q;
    assign locked       = locked_q;
    assign fail         = fail_q;
    assign slip_count_0 = slip0_q;
    assign slip_count_1 = slip1_q;

endmodule

// File: tb/tb_adc_frame_aligner.sv
// ---------------------------------------------------------------------------
// tb_adc_frame_aligner
//
// Testbench for adc_frame_aligner. An ADC model presents each lane as the
// pattern rotated by a per-lane offset. Each bitslip pulse takes one step off
// that offset. A lane can also be made to never match, or can get a one-cycle
// glitch. Expected results come from a window-level prediction of the
// training outcome.
// ---------------------------------------------------------------------------
module tb_adc_frame_aligner;

    logic        lclk = 1'b0;
    logic        rst_n = 1'b1;
    logic        start = 1'b0;
    logic [11:0] pattern = 12'd0;
    logic [11:0] adc_bits;
    logic [1:0]  adc_io_reset;
    logic [1:0]  adc_bitslip;
    logic        busy, locked, fail;
    logic [3:0]  slip_count_0, slip_count_1;

    // ADC model state
    int   rot0 = 0, rot1 = 0;
    int   load_r0 = 0, load_r1 = 0;
    logic load_req = 1'b0;
    logic nm0 = 1'b0, nm1 = 1'b0, glitch1 = 1'b0;
    logic parity = 1'b0;
    int   pulses0 = 0, pulses1 = 0;

    int vec_count = 0;
    int miscompares = 0;
    int k = 0;

    localparam logic [11:0] PAT = 12'b100110_001011;

    typedef struct {
        logic [11:0] pat;
        int          r0;
        int          r1;
        logic        nm0;
        logic        nm1;
        logic        exp_locked;
        logic        exp_fail;
        int          exp_s0;
        int          exp_s1;
        int          exp_lat;
    } vec_t;

    adc_frame_aligner dut (
        .lclk         (lclk),
        .rst_n        (rst_n),
        .start        (start),
        .pattern      (pattern),
        .adc_bits     (adc_bits),
        .adc_io_reset (adc_io_reset),
        .adc_bitslip  (adc_bitslip),
        .busy         (busy),
        .locked       (locked),
        .fail         (fail),
        .slip_count_0 (slip_count_0),
        .slip_count_1 (slip_count_1)
    );

    always #5 lclk = ~lclk;

    function automatic logic [5:0] rotl6(input logic [5:0] v, input int r);
        logic [11:0] t;
        t = {v, v} << r;
        return t[11:6];
    endfunction

    // A never-matching lane is inverted on every other cycle, so it misses
    // every check window regardless of its rotation.
    assign adc_bits[5:0]  = rotl6(pattern[5:0], rot0) ^
                            ((nm0 && parity) ? 6'h3F : 6'h00);
    assign adc_bits[11:6] = rotl6(pattern[11:6], rot1) ^
                            (((nm1 && parity) || glitch1) ? 6'h3F : 6'h00);

    // The ADC lane reacts to each bitslip pulse and counts the pulses it sees.
    always @(posedge lclk) begin
        parity <= ~parity;
        if (load_req) begin
            rot0 <= load_r0;
            rot1 <= load_r1;
        end else begin
            if (adc_bitslip[0]) rot0 <= (rot0 + 5) % 6;
            if (adc_bitslip[1]) rot1 <= (rot1 + 5) % 6;
        end
        if (adc_bitslip[0]) pulses0 <= pulses0 + 1;
        if (adc_bitslip[1]) pulses1 <= pulses1 + 1;
    end

    // Window-level prediction: every window either locks, fails or slips
    // each bad lane once. Each slip window costs 25 cycles after the
    // 29-cycle first window.
    function automatic vec_t predict(input logic [11:0] pat, input int a0,
                                     input int a1, input logic n0,
                                     input logic n1);
        vec_t v;
        int   r0, r1, s0, s1, t;
        bit   b0, b1;
        v.pat = pat; v.r0 = a0; v.r1 = a1; v.nm0 = n0; v.nm1 = n1;
        v.exp_locked = 1'b0; v.exp_fail = 1'b0;
        r0 = a0; r1 = a1; s0 = 0; s1 = 0; t = 29;
        for (int w = 0; w < 30; w++) begin
            b0 = n0 || (rotl6(pat[5:0], r0) != pat[5:0]);
            b1 = n1 || (rotl6(pat[11:6], r1) != pat[11:6]);
            if (!b0 && !b1) begin
                v.exp_locked = 1'b1;
                break;
            end
            if ((b0 && s0 == 12) || (b1 && s1 == 12)) begin
                v.exp_fail = 1'b1;
                break;
            end
            if (b0) begin s0++; r0 = (r0 + 5) % 6; end
            if (b1) begin s1++; r1 = (r1 + 5) % 6; end
            t += 25;
        end
        v.exp_s0 = s0; v.exp_s1 = s1; v.exp_lat = t;
        return v;
    endfunction

    task automatic checkOutput(input string name, input int actual,
                               input int expected);
        vec_count++;
        if (actual != expected) begin
            miscompares++;
            $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
        end
    endtask

    // Load the ADC model, pulse start and track cycles since the start cycle.
    task automatic kickOff(input logic [11:0] pat, input int a0, input int a1,
                           input logic n0, input logic n1);
        @(negedge lclk);
        pattern = pat; nm0 = n0; nm1 = n1;
        load_r0 = a0; load_r1 = a1; load_req = 1'b1;
        start = 1'b1;
        @(negedge lclk);
        start = 1'b0; load_req = 1'b0;
        k = 1;
    endtask

    task automatic waitTo(input int target);
        while (k < target) begin
            @(negedge lclk);
            k++;
        end
    endtask

    task automatic waitDone(input int limit);
        while (!(locked || fail) && k < limit) begin
            @(negedge lclk);
            k++;
        end
    endtask

    task automatic applyStimulus(input vec_t v, input string tag);
        int b0, b1;
        b0 = pulses0; b1 = pulses1;
        kickOff(v.pat, v.r0, v.r1, v.nm0, v.nm1);
        waitDone(2000);
        checkOutput({tag, "_latency"}, k, v.exp_lat);
        checkOutput({tag, "_locked"}, int'(locked), int'(v.exp_locked));
        checkOutput({tag, "_fail"}, int'(fail), int'(v.exp_fail));
        checkOutput({tag, "_busy"}, int'(busy), 0);
        checkOutput({tag, "_slip0"}, int'(slip_count_0), v.exp_s0);
        checkOutput({tag, "_slip1"}, int'(slip_count_1), v.exp_s1);
        checkOutput({tag, "_pulses0"}, pulses0 - b0, v.exp_s0);
        checkOutput({tag, "_pulses1"}, pulses1 - b1, v.exp_s1);
    endtask

    vec_t dir[5];

    initial begin
        int hi, nz;
        dir[0] = '{PAT, 0, 0, 1'b0, 1'b0, 1'b1, 1'b0, 0,  0,  29};
        dir[1] = '{PAT, 2, 0, 1'b0, 1'b0, 1'b1, 1'b0, 2,  0,  79};
        dir[2] = '{PAT, 0, 0, 1'b0, 1'b1, 1'b0, 1'b1, 0,  12, 329};
        dir[3] = '{PAT, 3, 5, 1'b0, 1'b0, 1'b1, 1'b0, 3,  5,  154};
        dir[4] = '{PAT, 1, 0, 1'b1, 1'b1, 1'b0, 1'b1, 12, 12, 329};

        // Reset state
        #2 rst_n = 1'b0;
        #6;
        checkOutput("rst_busy", int'(busy), 0);
        checkOutput("rst_locked", int'(locked), 0);
        checkOutput("rst_fail", int'(fail), 0);
        checkOutput("rst_io_reset", int'(adc_io_reset), 0);
        checkOutput("rst_bitslip", int'(adc_bitslip), 0);
        checkOutput("rst_slip0", int'(slip_count_0), 0);
        checkOutput("rst_slip1", int'(slip_count_1), 0);
        @(negedge lclk);
        rst_n = 1'b1;
        @(negedge lclk);

        for (int i = 0; i < 5; i++) begin
            applyStimulus(dir[i], $sformatf("dir%0d", i));
        end

        // Lane1 glitch in the first window: lane1 slips off its good alignment
        // and must walk all the way round before locking.
        kickOff(PAT, 0, 0, 1'b0, 1'b0);
        waitTo(20);
        glitch1 = 1'b1;
        @(negedge lclk);
        k++;
        glitch1 = 1'b0;
        waitTo(29);
        checkOutput("glitch_first_slip", int'(adc_bitslip), 2);
        waitTo(54);
        checkOutput("glitch_reslip", int'(adc_bitslip), 2);
        checkOutput("glitch_still_busy", int'(busy), 1);
        waitDone(2000);
        checkOutput("glitch_latency", k, 179);
        checkOutput("glitch_locked", int'(locked), 1);
        checkOutput("glitch_slip0", int'(slip_count_0), 0);
        checkOutput("glitch_slip1", int'(slip_count_1), 6);

        // start during CHECK is ignored; start after LOCKED retrains.
        kickOff(PAT, 0, 0, 1'b0, 1'b0);
        waitTo(15);
        start = 1'b1;
        @(negedge lclk);
        k++;
        start = 1'b0;
        waitDone(2000);
        checkOutput("busy_start_latency", k, 29);
        checkOutput("busy_start_locked", int'(locked), 1);
        @(negedge lclk);
        start = 1'b1;
        @(negedge lclk);
        start = 1'b0;
        checkOutput("restart_locked_drop", int'(locked), 0);
        checkOutput("restart_busy", int'(busy), 1);
        hi = 0;
        for (int i = 0; i < 6; i++) begin
            if (adc_io_reset == 2'b11) hi++;
            @(negedge lclk);
        end
        checkOutput("restart_io_reset_cycles", hi, 4);
        k = 7;
        waitDone(2000);
        checkOutput("restart_latency", k, 29);

        // Reset asserted during SLIP
        kickOff(PAT, 2, 0, 1'b0, 1'b0);
        while (adc_bitslip == 2'b00 && k < 200) begin
            @(negedge lclk);
            k++;
        end
        checkOutput("slip_seen", int'(adc_bitslip), 1);
        rst_n = 1'b0;
        #1;
        checkOutput("slip_rst_bitslip", int'(adc_bitslip), 0);
        checkOutput("slip_rst_busy", int'(busy), 0);
        checkOutput("slip_rst_slip0", int'(slip_count_0), 0);
        @(negedge lclk);
        rst_n = 1'b1;
        nz = 0;
        for (int i = 0; i < 60; i++) begin
            @(negedge lclk);
            if (adc_bitslip != 2'b00 || busy) nz++;
        end
        checkOutput("post_rst_quiet", nz, 0);
        checkOutput("post_rst_locked", int'(locked), 0);

        // Random patterns, offsets and dead lanes against the prediction
        for (int i = 0; i < 10; i++) begin
            vec_t v;
            v = predict(12'($urandom), int'($urandom_range(0, 5)),
                        int'($urandom_range(0, 5)),
                        $urandom_range(0, 5) == 0, $urandom_range(0, 5) == 0);
            applyStimulus(v, $sformatf("rnd%0d", i));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vec_count, miscompares);
        $finish;
    end

endmodule
